fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter NSRC, default 2, forwarding source count (index 0 = nearest stage, i.e. MEM; 1 = WB), legal 1..4.
REQ-002 Parameter LOAD_LAT, default 1, load-use bubbles inserted, legal 1..3.
REQ-003 Derived width FW = $clog2(NSRC+1) for forward select codes.
REQ-004 CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 nRST  in  1  reset, synchronous, active-low.
REQ-006 ex_rs, ex_rt  in  regbits_t  source registers of instruction in EX.
REQ-007 id_rs, id_rt  in  regbits_t  source registers of instruction in ID.
REQ-008 ex_dREN, ex_wsel  in  1, regbits_t  EX instruction is a load; its destination.
REQ-009 src_wsel  in  NSRC x regbits_t  destination of each forwarding source stage.
REQ-010 src_regwrite  in  NSRC  write-enable of each source stage.
REQ-011 mem_dREN, mem_dWEN, dhit  in  1 each  MEM-stage data request; data cache hit.
REQ-012 branch_taken  in  1  resolved taken branch/jump this cycle.
REQ-013 forwardA, forwardB  out  FW  0 = register file, k = src[k-1].
REQ-014 stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold pipeline register.
REQ-015 flush_id, flush_ex  out  1 each  insert bubble into ID/EX register.
REQ-016 stall_cnt  out  32  stall cycle count.

Function
REQ-017 forwardA SHALL select the lowest index k with src_regwrite[k], src_wsel[k]==ex_rs, src_wsel[k]!=0; code k+1; none -> 0; forwardB identically on ex_rt; combinational.
REQ-018 Load-use hazard (lu) SHALL be ex_dREN && ex_wsel!=0 && (ex_wsel==id_rs || ex_wsel==id_rt).
REQ-019 Miss condition (miss) SHALL be (mem_dREN || mem_dWEN) && !dhit.
REQ-020 FSM states IDLE, LU_STALL, MEM_WAIT; 2-bit bubble counter bcnt; 1-bit return flag ret_lu.
REQ-021 Any state, miss: assert all four stalls, no flush, enter/remain MEM_WAIT; ret_lu set if leaving LU_STALL; bcnt frozen.
REQ-022 MEM_WAIT, !miss (dhit cycle): all stalls low this cycle (Mealy); next state LU_STALL if ret_lu else IDLE.
REQ-023 IDLE, branch_taken, !miss: flush_id=flush_ex=1, no stall, stay IDLE; branch overrides lu.
REQ-024 IDLE, lu, !branch_taken, !miss: stall_if=stall_id=flush_ex=1 this cycle; LOAD_LAT==1 stay IDLE, else LU_STALL with bcnt=LOAD_LAT-1.
REQ-025 LU_STALL, !miss: stall_if=stall_id=flush_ex=1; bcnt decrements; bcnt==1 -> IDLE; total bubbles exactly LOAD_LAT.
REQ-026 LU_STALL, branch_taken: flush_id=flush_ex=1, stalls low, -> IDLE, bcnt cleared.
REQ-027 Forwarding SHALL remain valid in every state; r0 never forwarded.

Reset
REQ-028 nRST low at a rising edge: state IDLE, bcnt 0, ret_lu 0, stall_cnt 0.
REQ-029 While nRST low all stall/flush outputs SHALL be 0, forwardA/forwardB 0; reset mid-LU_STALL or mid-MEM_WAIT aborts without further bubbles.

Configuration
REQ-030 Macro HAZARD_PERF_EN defined: stall_cnt increments each cycle any stall_* is 1, saturates at 32'hFFFFFFFF.
REQ-031 Macro undefined: stall_cnt SHALL be constant 0, no counter flops.

Structure
REQ-032 regbits_t and a new hz_state_t enum (IDLE, LU_STALL, MEM_WAIT) SHALL live in cpu_types_pkg.
REQ-033 One sub-module fwd_sel (priority encoder, parameter NSRC), instantiated twice for A and B.
REQ-034 Existing hazard_if SHALL be extended with the new ports and a generalised modport pair (hi/tb).

Verification
REQ-035 NSRC=2: src_wsel={5,5}, regwrite={1,1}, ex_rs=5 -> forwardA=1; regwrite={0,1} -> forwardA=2; ex_rs=0 -> 0.
REQ-036 LOAD_LAT=2: ex_dREN=1, ex_wsel=8, id_rt=8 -> stall_if/stall_id/flush_ex high exactly 2 cycles, then IDLE.
REQ-037 Same lu with branch_taken=1 same cycle -> flush_id=flush_ex=1, stalls 0, no bubble next cycle.
REQ-038 mem_dREN=1, dhit=0 for 3 cycles during LU_STALL bcnt=1 -> 3 full-stall cycles, then exactly 1 remaining bubble.
REQ-039 HAZARD_PERF_EN defined, 5 stall cycles -> stall_cnt=5; nRST low one cycle mid-MEM_WAIT -> all outputs 0, stall_cnt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types -- register index and hazard controller state.
`default_nettype none

package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_if.sv
// hazard_if: bundle between pipeline datapath and fwd_hazard_ctrl (hi = controller side, tb = driver side).
`default_nettype none

interface hazard_if #(
  parameter int NSRC = 2
);
  import cpu_types_pkg::*;

  localparam int FW = $clog2(NSRC + 1);

  regbits_t               ex_rs;
  regbits_t               ex_rt;
  regbits_t               id_rs;
  regbits_t               id_rt;
  logic                   ex_dREN;
  regbits_t               ex_wsel;
  regbits_t [NSRC-1:0]    src_wsel;
  logic     [NSRC-1:0]    src_regwrite;
  logic                   mem_dREN;
  logic                   mem_dWEN;
  logic                   dhit;
  logic                   branch_taken;
  logic     [FW-1:0]      forwardA;
  logic     [FW-1:0]      forwardB;
  logic                   stall_if;
  logic                   stall_id;
  logic                   stall_ex;
  logic                   stall_mem;
  logic                   flush_id;
  logic                   flush_ex;
  logic     [31:0]        stall_cnt;

  modport hi (
    input  ex_rs, ex_rt, id_rs, id_rt, ex_dREN, ex_wsel, src_wsel, src_regwrite,
           mem_dREN, mem_dWEN, dhit, branch_taken,
    output forwardA, forwardB, stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, stall_cnt
  );

  modport tb (
    output ex_rs, ex_rt, id_rs, id_rt, ex_dREN, ex_wsel, src_wsel, src_regwrite,
           mem_dREN, mem_dWEN, dhit, branch_taken,
    input  forwardA, forwardB, stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/fwd_sel.sv
// fwd_sel: priority encoder picking the nearest writing stage whose destination matches rs.
`default_nettype none

module fwd_sel
  import cpu_types_pkg::*;
#(
  parameter int NSRC = 2
) (
  input  regbits_t                       rs,
  input  regbits_t [NSRC-1:0]            src_wsel,
  input  logic     [NSRC-1:0]            src_regwrite,
  output logic     [$clog2(NSRC+1)-1:0]  sel
);

  localparam int FW = $clog2(NSRC + 1);

  // Scan from the farthest stage down so the nearest match wins; r0 is never forwarded.
  always_comb begin
    sel = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (src_regwrite[k] && (src_wsel[k] == rs) && (rs != '0)) begin
        sel = FW'(k + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding select, load-use bubbles and D-cache miss stalls.
// Optional macro HAZARD_PERF_EN adds a saturating stall-cycle counter on stall_cnt.
`default_nettype none

module fwd_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic   CLK,
  input  logic   nRST,
  hazard_if.hi   hif
);

  localparam int         FW        = $clog2(NSRC + 1);
  localparam logic [1:0] BCNT_INIT = 2'(LOAD_LAT - 1);

  hz_state_t     state;
  logic [1:0]    bcnt;
  logic          ret_lu;
  logic          miss;
  logic          lu;
  logic          hold_front;
  logic          hold_back;
  logic          fl_id;
  logic          fl_ex;
  logic [FW-1:0] fsel_a;
  logic [FW-1:0] fsel_b;

  fwd_sel #(.NSRC(NSRC)) u_fwd_a (
    .rs           (hif.ex_rs),
    .src_wsel     (hif.src_wsel),
    .src_regwrite (hif.src_regwrite),
    .sel          (fsel_a)
  );

  fwd_sel #(.NSRC(NSRC)) u_fwd_b (
    .rs           (hif.ex_rt),
    .src_wsel     (hif.src_wsel),
    .src_regwrite (hif.src_regwrite),
    .sel          (fsel_b)
  );

  assign miss = (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;
  assign lu   = hif.ex_dREN && (hif.ex_wsel != '0) &&
                ((hif.ex_wsel == hif.id_rs) || (hif.ex_wsel == hif.id_rt));

  // Mealy controls: a miss freezes the whole pipe; the dhit cycle in MEM_WAIT releases it.
  always_comb begin
    hold_front = 1'b0;
    hold_back  = 1'b0;
    fl_id      = 1'b0;
    fl_ex      = 1'b0;
    if (miss) begin
      hold_front = 1'b1;
      hold_back  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hif.branch_taken) begin
            fl_id = 1'b1;
            fl_ex = 1'b1;
          end else if (lu) begin
            hold_front = 1'b1;
            fl_ex      = 1'b1;
          end
        end
        LU_STALL: begin
          if (hif.branch_taken) begin
            fl_id = 1'b1;
            fl_ex = 1'b1;
          end else begin
            hold_front = 1'b1;
            fl_ex      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hif.stall_if  = nRST && hold_front;
  assign hif.stall_id  = nRST && hold_front;
  assign hif.stall_ex  = nRST && hold_back;
  assign hif.stall_mem = nRST && hold_back;
  assign hif.flush_id  = nRST && fl_id;
  assign hif.flush_ex  = nRST && fl_ex;
  assign hif.forwardA  = nRST ? fsel_a : '0;
  assign hif.forwardB  = nRST ? fsel_b : '0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      bcnt   <= 2'd0;
      ret_lu <= 1'b0;
    end else if (miss) begin
      state <= MEM_WAIT;
      if (state == LU_STALL) begin
        ret_lu <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!hif.branch_taken && lu && (LOAD_LAT > 1)) begin
            state <= LU_STALL;
            bcnt  <= BCNT_INIT;
          end
        end
        LU_STALL: begin
          if (hif.branch_taken) begin
            state <= IDLE;
            bcnt  <= 2'd0;
          end else begin
            bcnt <= bcnt - 2'd1;
            if (bcnt == 2'd1) begin
              state <= IDLE;
            end
          end
        end
        MEM_WAIT: begin
          state  <= ret_lu ? LU_STALL : IDLE;
          ret_lu <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_cnt <= 32'd0;
    end else if ((hold_front || hold_back) && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign hif.stall_cnt = perf_cnt;
`else
  assign hif.stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: vector table, directed hazard sequences and randomized run against a bubble-count model.
`default_nettype none

module tb_fwd_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int NSRC     = 2;
  localparam int LOAD_LAT = 2;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector order: stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex
  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] BUBBLE = 6'b110001;
  localparam logic [5:0] FULL   = 6'b111100;
  localparam logic [5:0] FLUSH  = 6'b000011;

  logic CLK = 1'b0;
  logic nRST;
  int   tests = 0;
  int   fails = 0;

  hazard_if #(.NSRC(NSRC)) hif ();

  fwd_hazard_ctrl #(.NSRC(NSRC), .LOAD_LAT(LOAD_LAT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hif  (hif.hi)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   w0;
    regbits_t   w1;
    logic [1:0] rw;
    logic [1:0] ea;
    logic [1:0] eb;
  } fwd_vec_t;

  fwd_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    hif.ex_rs        = '0;
    hif.ex_rt        = '0;
    hif.id_rs        = '0;
    hif.id_rt        = '0;
    hif.ex_dREN      = 1'b0;
    hif.ex_wsel      = '0;
    hif.src_wsel[0]  = '0;
    hif.src_wsel[1]  = '0;
    hif.src_regwrite = '0;
    hif.mem_dREN     = 1'b0;
    hif.mem_dWEN     = 1'b0;
    hif.dhit         = 1'b1;
    hif.branch_taken = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  function automatic logic [5:0] ctl();
    return {hif.stall_if, hif.stall_id, hif.stall_ex, hif.stall_mem, hif.flush_id, hif.flush_ex};
  endfunction

  function automatic logic [1:0] ref_fwd(input regbits_t r);
    for (int k = 0; k < NSRC; k++) begin
      if (hif.src_regwrite[k] && hif.src_wsel[k] == r && r != 5'd0) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int       pend;
    int       cnt;
    bit       prev_miss;
    bit       miss;
    bit       lu;
    logic [5:0] exp_ctl;
    logic [1:0] ea;
    logic [1:0] eb;

    vecs[0] = '{5'd5,  5'd0,  5'd5,  5'd5,  2'b11, 2'd1, 2'd0};
    vecs[1] = '{5'd5,  5'd5,  5'd5,  5'd5,  2'b10, 2'd2, 2'd2};
    vecs[2] = '{5'd0,  5'd5,  5'd0,  5'd0,  2'b11, 2'd0, 2'd0};
    vecs[3] = '{5'd3,  5'd7,  5'd7,  5'd3,  2'b11, 2'd2, 2'd1};
    vecs[4] = '{5'd3,  5'd3,  5'd3,  5'd3,  2'b00, 2'd0, 2'd0};
    vecs[5] = '{5'd31, 5'd12, 5'd31, 5'd12, 2'b01, 2'd1, 2'd0};

    // Reset with hazards present on every input: outputs must stay quiet.
    nRST = 1'b0;
    quiet();
    hif.ex_rs = 5'd5; hif.ex_rt = 5'd5;
    hif.src_wsel[0] = 5'd5; hif.src_wsel[1] = 5'd5; hif.src_regwrite = 2'b11;
    hif.ex_dREN = 1'b1; hif.ex_wsel = 5'd8; hif.id_rt = 5'd8;
    hif.mem_dREN = 1'b1; hif.dhit = 1'b0;
    sample();
    chk("rst_ctl", 32'(ctl()), 32'(NONE));
    chk("rst_fwdA", 32'(hif.forwardA), 32'd0);
    chk("rst_fwdB", 32'(hif.forwardB), 32'd0);
    chk("rst_cnt", hif.stall_cnt, 32'd0);
    next_cyc();
    nRST = 1'b1;
    quiet();
    sample();
    chk("idle_ctl", 32'(ctl()), 32'(NONE));
    next_cyc();

    for (int i = 0; i < 6; i++) begin
      hif.ex_rs = vecs[i].rs;
      hif.ex_rt = vecs[i].rt;
      hif.src_wsel[0] = vecs[i].w0;
      hif.src_wsel[1] = vecs[i].w1;
      hif.src_regwrite = vecs[i].rw;
      sample();
      chk($sformatf("vec%0d_fwdA", i), 32'(hif.forwardA), 32'(vecs[i].ea));
      chk($sformatf("vec%0d_fwdB", i), 32'(hif.forwardB), 32'(vecs[i].eb));
      next_cyc();
    end
    quiet();

    // Load-use with LOAD_LAT=2: exactly two bubbles.
    hif.ex_dREN = 1'b1; hif.ex_wsel = 5'd8; hif.id_rs = 5'd1; hif.id_rt = 5'd8;
    sample();
    chk("lu_bubble1", 32'(ctl()), 32'(BUBBLE));
    next_cyc();
    quiet();
    sample();
    chk("lu_bubble2", 32'(ctl()), 32'(BUBBLE));
    next_cyc();
    sample();
    chk("lu_done", 32'(ctl()), 32'(NONE));
    next_cyc();

    // Branch in the same cycle as a load-use wins.
    hif.ex_dREN = 1'b1; hif.ex_wsel = 5'd8; hif.id_rt = 5'd8; hif.branch_taken = 1'b1;
    sample();
    chk("br_over_lu", 32'(ctl()), 32'(FLUSH));
    next_cyc();
    quiet();
    sample();
    chk("br_no_bubble", 32'(ctl()), 32'(NONE));
    next_cyc();

    // Miss arriving while one load-use bubble is still owed.
    hif.ex_dREN = 1'b1; hif.ex_wsel = 5'd8; hif.id_rs = 5'd8;
    sample();
    chk("lum_bubble1", 32'(ctl()), 32'(BUBBLE));
    next_cyc();
    quiet();
    hif.mem_dREN = 1'b1; hif.dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("lum_miss%0d", i), 32'(ctl()), 32'(FULL));
      next_cyc();
    end
    hif.dhit = 1'b1;
    sample();
    chk("lum_dhit", 32'(ctl()), 32'(NONE));
    next_cyc();
    quiet();
    sample();
    chk("lum_bubble2", 32'(ctl()), 32'(BUBBLE));
    next_cyc();
    sample();
    chk("lum_done", 32'(ctl()), 32'(NONE));
    chk("lum_cnt", hif.stall_cnt, PERF ? 32'd7 : 32'd0);
    next_cyc();

    // Five miss cycles, then reset in the middle of MEM_WAIT.
    nRST = 1'b0;
    next_cyc();
    nRST = 1'b1;
    hif.mem_dWEN = 1'b1; hif.dhit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      next_cyc();
    end
    sample();
    chk("perf_cnt5", hif.stall_cnt, PERF ? 32'd5 : 32'd0);
    chk("perf_full", 32'(ctl()), 32'(FULL));
    nRST = 1'b0;
    #1;
    chk("mw_rst_ctl", 32'(ctl()), 32'(NONE));
    next_cyc();
    nRST = 1'b1;
    quiet();
    sample();
    chk("mw_rst_cnt", hif.stall_cnt, 32'd0);
    chk("mw_rst_idle", 32'(ctl()), 32'(NONE));
    next_cyc();

    // Randomized run against the remaining-bubble model.
    nRST = 1'b0;
    quiet();
    next_cyc();
    pend = 0; cnt = 0; prev_miss = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      nRST             = ($urandom_range(0, 99) >= 2);
      hif.ex_rs        = 5'($urandom_range(0, 3));
      hif.ex_rt        = 5'($urandom_range(0, 3));
      hif.id_rs        = 5'($urandom_range(0, 3));
      hif.id_rt        = 5'($urandom_range(0, 3));
      hif.ex_wsel      = 5'($urandom_range(0, 3));
      hif.src_wsel[0]  = 5'($urandom_range(0, 3));
      hif.src_wsel[1]  = 5'($urandom_range(0, 3));
      hif.src_regwrite = 2'($urandom_range(0, 3));
      hif.ex_dREN      = ($urandom_range(0, 99) < 50);
      hif.branch_taken = ($urandom_range(0, 99) < 15);
      hif.mem_dREN     = ($urandom_range(0, 99) < 25);
      hif.mem_dWEN     = ($urandom_range(0, 99) < 10);
      hif.dhit         = ($urandom_range(0, 99) < 50);
      sample();
      miss = (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;
      lu   = hif.ex_dREN && hif.ex_wsel != 5'd0 &&
             (hif.ex_wsel == hif.id_rs || hif.ex_wsel == hif.id_rt);
      exp_ctl = NONE; ea = 2'd0; eb = 2'd0;
      if (nRST) begin
        ea = ref_fwd(hif.ex_rs);
        eb = ref_fwd(hif.ex_rt);
        if (miss)                  exp_ctl = FULL;
        else if (prev_miss)        exp_ctl = NONE;
        else if (hif.branch_taken) exp_ctl = FLUSH;
        else if (pend > 0 || lu)   exp_ctl = BUBBLE;
      end
      chk("rand_ctl", 32'(ctl()), 32'(exp_ctl));
      chk("rand_fwdA", 32'(hif.forwardA), 32'(ea));
      chk("rand_fwdB", 32'(hif.forwardB), 32'(eb));
      chk("rand_cnt", hif.stall_cnt, PERF ? 32'(cnt) : 32'd0);
      if (!nRST) begin
        pend = 0; cnt = 0; prev_miss = 1'b0;
      end else begin
        if (exp_ctl[5:2] != 4'b0) cnt++;
        if (miss)                  prev_miss = 1'b1;
        else if (prev_miss)        prev_miss = 1'b0;
        else if (hif.branch_taken) pend = 0;
        else if (pend > 0)         pend--;
        else if (lu)               pend = LOAD_LAT - 1;
      end
      next_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
